// File: rtl/residual_add_pkg.sv
// residual_add_pkg
//   Shared helpers for the residual add stream:
//   - beats_f      : number of beats per token (DIMENTION / LANES)
//   - sat_max_f    : most positive value of a signed field of the given width
//   - sat_min_f    : most negative value of a signed field of the given width
//   - clip         : clamps (or passes through) a wide signed value and reports
//                    whether it clamped, packed as {sat, result}
//   Values are carried in a MAXW-bit container so that one function serves
//   every width. Callers keep only the low bits they need.
package residual_add_pkg;

  localparam int MAXW = 64;

  typedef struct packed {
    logic             sat;
    logic [MAXW-1:0]  result;
  } clip_t;

  function automatic int beats_f(input int dimention, input int lanes);
    return dimention / lanes;
  endfunction

  function automatic logic signed [MAXW-1:0] sat_max_f(input int width);
    logic [MAXW-1:0] one;
    one = MAXW'(1);
    return signed'((one << (width - 1)) - one);
  endfunction

  function automatic logic signed [MAXW-1:0] sat_min_f(input int width);
    logic [MAXW-1:0] one;
    one = MAXW'(1);
    return signed'(~((one << (width - 1)) - one));
  endfunction

  // Without saturation the value is returned unchanged; the caller's
  // truncation to its own width gives two's-complement wrap. When the output
  // is wider than the exact result, no clamp can trigger, so sat stays 0.
  function automatic clip_t clip(input logic signed [MAXW-1:0] value,
                                 input int                     width,
                                 input bit                     saturate);
    clip_t c;
    c.sat    = 1'b0;
    c.result = value;
    if (saturate) begin
      if (value > sat_max_f(width)) begin
        c.sat    = 1'b1;
        c.result = sat_max_f(width);
      end else if (value < sat_min_f(width)) begin
        c.sat    = 1'b1;
        c.result = sat_min_f(width);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_clip_lane.sv
// sat_clip_lane
//   One lane of the output stage: takes the exact (WIDTH_IN)-bit signed sum
//   and produces the WIDTH_OUT-bit output element, either clamped
//   (SATURATE=1) or wrapped (SATURATE=0).
// Ports
//   raw     in   WIDTH_IN   exact signed sum/difference from the first stage
//   result  out  WIDTH_OUT  output element
//   sat     out  1          high when this lane was clamped
module sat_clip_lane
  import residual_add_pkg::*;
#(
  parameter int WIDTH_IN  = 33,
  parameter int WIDTH_OUT = 32,
  parameter int SATURATE  = 1
) (
  input  logic signed [WIDTH_IN-1:0]  raw,
  output logic        [WIDTH_OUT-1:0] result,
  output logic                        sat
);

  clip_t                       c;
  logic [MAXW-1:WIDTH_OUT]     hi_unused;

  always_comb begin
    c = clip(MAXW'(raw), WIDTH_OUT, SATURATE != 0);
  end

  assign result    = c.result[WIDTH_OUT-1:0];
  assign sat       = c.sat;
  // Upper container bits are either sign copies or discarded by the wrap.
  assign hi_unused = c.result[MAXW-1:WIDTH_OUT];

endmodule

// File: rtl/residual_add_stream.sv
// residual_add_stream
//   Streaming element-wise residual adder. A token of DIMENTION elements
//   arrives as BEATS = DIMENTION/LANES beats of LANES signed elements per
//   operand. Two register stages: S1 holds the exact per-lane sum or
//   difference, S2 holds the clipped output. Accept-to-out_valid latency is
//   two cycles; full throughput with no bubble when out_ready stays high.
// Ports
//   clk        in   1                  rising-edge clock
//   rst_n      in   1                  asynchronous active-low reset
//   in_valid   in   1                  input beat valid
//   in_ready   out  1                  input beat accepted on in_valid && in_ready
//   mode_sub   in   1                  0: addend1+addend2, 1: addend1-addend2 (per beat)
//   addend1    in   LANES*WIDTH_ADDEND lane i at [(i+1)*WIDTH_ADDEND-1 : i*WIDTH_ADDEND]
//   addend2    in   LANES*WIDTH_ADDEND same packing
//   out_valid  out  1                  output beat valid
//   out_ready  in   1                  downstream accepts on out_valid && out_ready
//   sum        out  LANES*WIDTH_SUM    lane i at [(i+1)*WIDTH_SUM-1 : i*WIDTH_SUM]
//   out_last   out  1                  final beat of a token
//   out_sat    out  1                  at least one lane clamped in this beat
//   token_cnt  out  16                 tokens fully emitted since reset (wraps)
module residual_add_stream
  import residual_add_pkg::*;
#(
  parameter int LANES        = 16,
  parameter int DIMENTION    = 768,
  parameter int WIDTH_ADDEND = 32,
  parameter int WIDTH_SUM    = 32,
  parameter int SATURATE     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            mode_sub,
  input  logic [LANES*WIDTH_ADDEND-1:0]   addend1,
  input  logic [LANES*WIDTH_ADDEND-1:0]   addend2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*WIDTH_SUM-1:0]      sum,
  output logic                            out_last,
  output logic                            out_sat,
  output logic [15:0]                     token_cnt
);

  localparam int BEATS = beats_f(DIMENTION, LANES);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WR    = WIDTH_ADDEND + 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  if (DIMENTION % LANES != 0) begin : g_chk_dim
    $error("residual_add_stream: DIMENTION must be a multiple of LANES");
  end
  if (WIDTH_SUM < WIDTH_ADDEND) begin : g_chk_width
    $error("residual_add_stream: WIDTH_SUM must be >= WIDTH_ADDEND");
  end
  if (WIDTH_SUM >= MAXW || WR >= MAXW) begin : g_chk_max
    $error("residual_add_stream: element widths must stay below the clip container width");
  end

  logic                    s1_valid;
  logic                    s1_last;
  logic [LANES*WR-1:0]     s1_raw;
  logic [LANES*WR-1:0]     raw_next;
  logic [LANES*WIDTH_SUM-1:0] clip_res;
  logic [LANES-1:0]        clip_sat;
  logic [BCW-1:0]          in_beat_cnt;
  logic                    s1_ready;
  logic                    s2_ready;
  logic                    in_fire;
  logic                    out_fire;

  // Each stage may take a new beat when empty or when its content leaves in
  // the same cycle, so a full pipeline still moves one beat per cycle.
  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WR-1:0] op1;
    logic signed [WR-1:0] op2;

    // One extra bit makes the sum/difference exact for any operand pair.
    assign op1 = {addend1[(i+1)*WIDTH_ADDEND-1], addend1[i*WIDTH_ADDEND +: WIDTH_ADDEND]};
    assign op2 = {addend2[(i+1)*WIDTH_ADDEND-1], addend2[i*WIDTH_ADDEND +: WIDTH_ADDEND]};
    assign raw_next[i*WR +: WR] = mode_sub ? (op1 - op2) : (op1 + op2);

    sat_clip_lane #(
      .WIDTH_IN  (WR),
      .WIDTH_OUT (WIDTH_SUM),
      .SATURATE  (SATURATE)
    ) u_clip (
      .raw    (s1_raw[i*WR +: WR]),
      .result (clip_res[i*WIDTH_SUM +: WIDTH_SUM]),
      .sat    (clip_sat[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_beat_cnt <= '0;
    end else if (in_fire) begin
      in_beat_cnt <= (in_beat_cnt == LAST_BEAT) ? '0 : in_beat_cnt + BCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_raw   <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_raw  <= raw_next;
        s1_last <= (in_beat_cnt == LAST_BEAT);
      end
    end
  end

  // Output registers only change when S2 can advance, which keeps a stalled
  // beat stable until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum      <= clip_res;
        out_last <= s1_last;
        out_sat  <= |clip_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      token_cnt <= '0;
    end else if (out_fire && out_last) begin
      token_cnt <= token_cnt + 16'd1;
    end
  end

endmodule
